// File: rtl/prog_loader.sv
// prog_loader
// -----------------------------------------------------------------------------
// Byte-stream program loader and write side of the CPU instruction BRAM.
// A framed program arrives over a valid/ready byte interface:
//   SYNC, LEN_HI, LEN_LO, LEN*8 instruction bytes, CSUM
// LEN is a big-endian instruction count and CSUM is the 8-bit wrap-around sum
// of the instruction bytes. Instruction bytes go to BRAM addresses 0,1,2,...
// in arrival order. The CPU is held in reset for the whole load and is only
// released once a frame has loaded with a matching checksum.
//
// Ports:
//   Clk       system clock
//   Rst       asynchronous, active-high reset
//   in_data   incoming stream byte
//   in_valid  in_data valid
//   in_ready  loader accepts a byte (no backpressure, high whenever Rst is low)
//   mem_we    BRAM write enable (wea), one cycle per instruction byte
//   mem_addr  BRAM byte address (addra)
//   mem_din   BRAM write data (dina)
//   cpu_hold  high = keep CPU in reset and give the BRAM port to the loader
//   done      frame loaded and checksum OK
//   error     frame aborted (oversize, bad checksum or timeout)
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int         ADDR_W    = 16,
  parameter int         MAX_INSTR = 8192,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // One bit wider than the address so LEN*8 for a full 64 KiB frame fits.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(MAX_INSTR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        len_hi;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        csum;
  logic [IDLE_W-1:0] idle_cnt;

  logic        xfer;
  logic [15:0] len;
  logic        in_frame;
  logic        sync_start;
  logic        timed_out;
  logic        len_load;

  // The BRAM swallows a byte every cycle, so the only time we refuse data is
  // while reset is held.
  assign in_ready = ~Rst;
  assign xfer     = in_valid & in_ready;
  assign len      = {len_hi, in_data};

  assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);

  // SYNC only restarts a load from the resting states; inside a frame it is
  // ordinary length/data/checksum content.
  assign sync_start = xfer && (in_data == SYNC) &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  // The idle cycle that would bring the counter up to TIMEOUT aborts the frame.
  assign timed_out = in_frame && !xfer && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign len_load = (state == S_LEN_LO) && xfer &&
                    ({1'b0, len} <= MAX_LEN) && (len != 16'd0);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded status outputs
  always_comb begin
    state_next = state;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (sync_start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, len} > MAX_LEN) state_next = S_ERROR;
          else if (len == 16'd0)     state_next = S_CHECK;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (byte_cnt == CNT_W'(1))) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) state_next = (in_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase

    if (timed_out) state_next = S_ERROR;

    if (state == S_DONE) begin
      done     = 1'b1;
      cpu_hold = 1'b0;
    end
    if (state == S_ERROR) error = 1'b1;
  end

  // Datapath: length capture, byte counter, checksum, BRAM write port and the
  // inter-byte idle counter. A data byte accepted on an edge is presented on
  // the BRAM port for the following cycle, so the BRAM writes it on the next
  // edge and consecutive bytes produce consecutive writes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      len_hi   <= '0;
      byte_cnt <= '0;
      wr_addr  <= '0;
      csum     <= '0;
      idle_cnt <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_we <= 1'b0;

      if (sync_start) begin
        csum     <= '0;
        wr_addr  <= '0;
        byte_cnt <= '0;
      end

      if ((state == S_LEN_HI) && xfer) len_hi <= in_data;

      if (len_load) byte_cnt <= CNT_W'({len, 3'b000});

      if ((state == S_DATA) && xfer) begin
        csum     <= csum + in_data;
        byte_cnt <= byte_cnt - CNT_W'(1);
        mem_we   <= 1'b1;
        mem_addr <= wr_addr;
        mem_din  <= in_data;
        wr_addr  <= wr_addr + ADDR_W'(1);
      end

      // Idle counter only runs inside a frame and saturates at TIMEOUT.
      if (!in_frame || xfer) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. The stimulus thread drives directed
// frames and, for every instruction byte it sends, pushes the BRAM write it
// expects (address, data, cycle) into a queue. A separate monitor pops that
// queue whenever the DUT raises mem_we and compares. Status outputs are
// checked directly by the stimulus thread at known points.
module tb_prog_loader;

  localparam int TB_TIMEOUT = 40;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        Clk;
  logic        Rst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memDin;
  logic        cpuHold;
  logic        done;
  logic        error;

  int          testsRun   = 0;
  int          testsFail  = 0;
  int          cyc        = 0;
  int          writesSeen = 0;
  logic [15:0] expAddr    = '0;
  wr_t         expQ[$];
  logic [7:0]  payload[$];

  prog_loader #(
    .ADDR_W   (16),
    .MAX_INSTR(8192),
    .SYNC     (8'hA5),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .in_data (inData),
    .in_valid(inValid),
    .in_ready(inReady),
    .mem_we  (memWe),
    .mem_addr(memAddr),
    .mem_din (memDin),
    .cpu_hold(cpuHold),
    .done    (done),
    .error   (error)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle stamp used to check that each write shows up in the cycle right
  // after its byte was accepted.
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard monitor: sample on the falling edge, away from input changes.
  always @(negedge Clk) begin
    if (memWe) begin
      writesSeen++;
      testsRun++;
      if (expQ.size() == 0) begin
        testsFail++;
        $display("[TB] FAIL unexpected write: addr %0h data %0h at cycle %0d, none expected",
                 memAddr, memDin, cyc);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        if (memAddr !== e.addr || memDin !== e.data || cyc != e.cyc) begin
          testsFail++;
          $display("[TB] FAIL bram write: got addr %0h data %0h cycle %0d, expected addr %0h data %0h cycle %0d",
                   memAddr, memDin, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Safety net so the run always ends even if something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Send one byte, optionally after some idle cycles with in_valid low. Data
  // bytes register the write they should cause with the scoreboard.
  task automatic applyStimulus(input logic [7:0] b, input bit isData, input int gap);
    repeat (gap) begin
      @(posedge Clk);
      #1;
    end
    inData  = b;
    inValid = 1'b1;
    @(posedge Clk);
    #1;
    inValid = 1'b0;
    if (isData) begin
      expQ.push_back('{addr: expAddr, data: b, cyc: cyc});
      expAddr++;
    end
  endtask

  // Full frame built from the global payload queue, with a supplied checksum.
  task automatic sendFrame(input logic [7:0] csum, input int gap);
    logic [15:0] len;
    len     = 16'(payload.size() / 8);
    expAddr = '0;
    applyStimulus(8'hA5, 1'b0, gap);
    applyStimulus(len[15:8], 1'b0, gap);
    applyStimulus(len[7:0], 1'b0, gap);
    foreach (payload[i]) applyStimulus(payload[i], 1'b1, gap);
    applyStimulus(csum, 1'b0, gap);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, inReady, 0);
    checkOutput({tag, " mem_we"},   memWe,   0);
    checkOutput({tag, " mem_addr"}, memAddr, 0);
    checkOutput({tag, " mem_din"},  memDin,  0);
    checkOutput({tag, " cpu_hold"}, cpuHold, 1);
    checkOutput({tag, " done"},     done,    0);
    checkOutput({tag, " error"},    error,   0);
  endtask

  task automatic doReset;
    Rst     = 1'b1;
    inValid = 1'b0;
    #2;
    checkResetValues("reset");
    repeat (2) @(posedge Clk);
    #1;
    Rst     = 1'b0;
    expAddr = '0;
    #1;
    checkOutput("in_ready after reset", inReady, 1);
  endtask

  // Let in-flight writes reach the monitor, then confirm the write count for
  // the test and that nothing expected is still outstanding.
  task automatic drainAndCount(input string tag, input int base, input int expWrites);
    repeat (2) @(posedge Clk);
    #1;
    checkOutput({tag, " write count"}, writesSeen - base, expWrites);
    checkOutput({tag, " writes pending"}, expQ.size(), 0);
  endtask

  initial begin
    int base;
    Rst     = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;
    doReset();

    // Happy path, back-to-back bytes: sum of 01..08 is 0x24.
    base = writesSeen;
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    sendFrame(8'h24, 0);
    checkOutput("happy done", done, 1);
    checkOutput("happy cpu_hold", cpuHold, 0);
    checkOutput("happy error", error, 0);
    drainAndCount("happy", base, 8);

    // Bad checksum: writes still happen, frame ends in error.
    base = writesSeen;
    sendFrame(8'h25, 0);
    checkOutput("badcsum error", error, 1);
    checkOutput("badcsum done", done, 0);
    checkOutput("badcsum cpu_hold", cpuHold, 1);
    drainAndCount("badcsum", base, 8);

    // SYNC alone clears the error, then a correct frame completes.
    base    = writesSeen;
    expAddr = '0;
    applyStimulus(8'hA5, 1'b0, 0);
    checkOutput("resync error", error, 0);
    checkOutput("resync cpu_hold", cpuHold, 1);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    foreach (payload[i]) applyStimulus(payload[i], 1'b1, 0);
    applyStimulus(8'h24, 1'b0, 0);
    checkOutput("resync done", done, 1);
    drainAndCount("resync", base, 8);

    // Oversize LEN = 8193, then empty LEN = 0 with checksum 00.
    base = writesSeen;
    applyStimulus(8'hA5, 1'b0, 0);
    applyStimulus(8'h20, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    checkOutput("oversize error", error, 1);
    checkOutput("oversize cpu_hold", cpuHold, 1);
    applyStimulus(8'hA5, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    checkOutput("empty done", done, 1);
    checkOutput("empty error", error, 0);
    drainAndCount("oversize/empty", base, 0);

    // Noise before SYNC is ignored; then the frame with in_valid toggling.
    doReset();
    base = writesSeen;
    applyStimulus(8'h11, 1'b0, 0);
    applyStimulus(8'h22, 1'b0, 0);
    checkOutput("noise done", done, 0);
    checkOutput("noise error", error, 0);
    checkOutput("noise cpu_hold", cpuHold, 1);
    sendFrame(8'h24, 1);
    checkOutput("gapped done", done, 1);
    drainAndCount("gapped", base, 8);

    // SYNC byte inside the data is just data.
    base = writesSeen;
    payload = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sendFrame(8'hA5, 0);
    checkOutput("sync-as-data done", done, 1);
    drainAndCount("sync-as-data", base, 8);

    // Timeout after three data bytes: still fine one cycle short, error at the limit.
    base    = writesSeen;
    expAddr = '0;
    applyStimulus(8'hA5, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    applyStimulus(8'h01, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    applyStimulus(8'h03, 1'b1, 0);
    repeat (TB_TIMEOUT - 1) @(posedge Clk);
    #1;
    checkOutput("timeout not yet", error, 0);
    @(posedge Clk);
    #1;
    checkOutput("timeout error", error, 1);
    checkOutput("timeout cpu_hold", cpuHold, 1);
    drainAndCount("timeout", base, 3);

    // Reset mid-frame after five data bytes, asserted between clock edges.
    doReset();
    base = writesSeen;
    applyStimulus(8'hA5, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 0);
    #5;
    Rst = 1'b1;
    #1;
    checkResetValues("midframe reset");
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    checkOutput("midframe write count", writesSeen - base, 5);
    checkOutput("midframe writes pending", expQ.size(), 0);

    // A fresh frame after the abort loads from address 0 again.
    base = writesSeen;
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    sendFrame(8'h24, 0);
    checkOutput("post-reset done", done, 1);
    drainAndCount("post-reset", base, 8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
